// File: rtl/req_enc_pkg.sv
// Shared constants, state type and helpers for the 4-to-2 request encoder.
package req_enc_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned CODE_W = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } req_enc_state_t;

  // One-hot expansion of a 2-bit code onto the request lines.
  function automatic logic [N_REQ-1:0] onehot4(input logic [CODE_W-1:0] code);
    onehot4 = N_REQ'(1) << code;
  endfunction

endpackage

// File: rtl/req_encoder_4to2_if.sv
// Request/code handshake bundle between the encoder and its environment.
interface req_encoder_4to2_if;
  import req_enc_pkg::*;

  logic [N_REQ-1:0]  in;
  logic              ack;
  logic [CODE_W-1:0] out;
  logic              valid;
  logic [N_REQ-1:0]  pending;
  logic              dup;

  // Encoder side.
  modport slave (
    input  in,
    input  ack,
    output out,
    output valid,
    output pending,
    output dup
  );

  // Requester / consumer side.
  modport master (
    output in,
    output ack,
    input  out,
    input  valid,
    input  pending,
    input  dup
  );

endinterface

// File: rtl/pri_enc_4to2.sv
// Combinational highest-index-first priority encoder with an any-bit flag.
module pri_enc_4to2
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  v,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Highest set bit wins.
  always_comb begin
    code = '0;
    any  = 1'b0;
    casez (v)
      4'b1???: begin code = CODE_W'(3); any = 1'b1; end
      4'b01??: begin code = CODE_W'(2); any = 1'b1; end
      4'b001?: begin code = CODE_W'(1); any = 1'b1; end
      4'b0001: begin code = CODE_W'(0); any = 1'b1; end
      default: begin code = '0;         any = 1'b0; end
    endcase
  end

endmodule

// File: rtl/req_encoder_4to2.sv
// Sequential 4-to-2 request encoder: sticky pending register, codes presented
// highest index first under a valid/ack handshake.
module req_encoder_4to2
  import req_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  req_encoder_4to2_if.slave  bus
);

  req_enc_state_t    state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [CODE_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              dup_q, dup_d;

  logic              accept_c;
  logic [N_REQ-1:0]  clr_c;
  logic [N_REQ-1:0]  rem_c;
  logic [CODE_W-1:0] pend_code_c, rem_code_c;
  logic              pend_any_c, rem_any_c;

  // Handshake completion, clear mask and what remains after the served code.
  always_comb begin
    accept_c = valid_q & bus.ack;
    clr_c    = accept_c ? onehot4(out_q) : '0;
    rem_c    = pending_q & ~onehot4(out_q);
  end

  // Selection from the registered pending set (IDLE).
  pri_enc_4to2 u_pri_pending (
    .v    (pending_q),
    .code (pend_code_c),
    .any  (pend_any_c)
  );

  // Selection from the remaining set on an accepted code (PRESENT).
  pri_enc_4to2 u_pri_rem (
    .v    (rem_c),
    .code (rem_code_c),
    .any  (rem_any_c)
  );

  // Next-state, next-code and pending/dup update; new requests win over clear.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    valid_d   = valid_q;
    pending_d = (pending_q & ~clr_c) | bus.in;
    dup_d     = |(bus.in & pending_q & ~clr_c);

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pend_any_c) begin
          out_d   = pend_code_c;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        valid_d = 1'b1;
        if (accept_c) begin
          if (rem_any_c) begin
            out_d = rem_code_c;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      dup_q     <= dup_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;
  assign bus.dup     = dup_q;

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Self-checking bench for req_encoder_4to2: directed table, corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_req_encoder_4to2;

  logic clk;
  logic rst_n;

  req_encoder_4to2_if bus ();

  req_encoder_4to2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic       ack;
    logic [1:0] exp_out;
    logic       exp_valid;
    logic [3:0] exp_pend;
    logic       exp_dup;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: pending set, presented code, valid, dup.
  int m_pend  = 0;
  int m_out   = 0;
  bit m_valid = 1'b0;
  bit m_dup   = 1'b0;

  function automatic int highest(input int v);
    for (int i = 3; i >= 0; i--) begin
      if (((v >> i) & 1) != 0) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_out   = 0;
    m_valid = 1'b0;
    m_dup   = 1'b0;
  endtask

  task automatic model_step(input int in_v, input bit ack_v);
    int clr;
    int rem;
    int np;
    bit acc;
    acc   = m_valid && ack_v;
    clr   = acc ? (1 << m_out) : 0;
    np    = ((m_pend & ~clr) | in_v) & 15;
    m_dup = (in_v & m_pend & ~clr) != 0;
    if (!m_valid) begin
      if (m_pend != 0) begin
        m_out   = highest(m_pend);
        m_valid = 1'b1;
      end
    end else if (acc) begin
      rem = m_pend & ~clr & 15;
      if (rem != 0) m_out = highest(rem);
      else          m_valid = 1'b0;
    end
    m_pend = np;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int e_out, input int e_valid,
                         input int e_pend, input int e_dup);
    chk({nm, ".valid"},   int'(bus.valid),   e_valid);
    if (e_valid != 0 || e_out >= 0) chk({nm, ".out"}, int'(bus.out), e_out);
    chk({nm, ".pending"}, int'(bus.pending), e_pend);
    chk({nm, ".dup"},     int'(bus.dup),     e_dup);
  endtask

  // One clock: drive at negedge, advance model at posedge, sample at negedge.
  task automatic step(input int in_v, input bit ack_v);
    bus.in  = 4'(in_v);
    bus.ack = ack_v;
    @(posedge clk);
    model_step(in_v, ack_v);
    @(negedge clk);
  endtask

  task automatic step_chk_model(input string nm, input int in_v, input bit ack_v);
    step(in_v, ack_v);
    chk_all(nm, m_out, int'(m_valid), m_pend, int'(m_dup));
  endtask

  task automatic add(input logic [3:0] i, input logic a, input logic [1:0] o,
                     input logic v, input logic [3:0] p, input logic d);
    vec_t t;
    t.in = i; t.ack = a; t.exp_out = o; t.exp_valid = v; t.exp_pend = p; t.exp_dup = d;
    tbl.push_back(t);
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.in  = 4'b0000;
    bus.ack = 1'b0;

    // Directed vectors from reset (hand-derived expectations).
    add(4'b0100, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b0); // single request captured
    add(4'b0000, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0); // presented two edges later
    add(4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0); // ack clears, back to idle
    add(4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0); // ack with valid=0 ignored
    add(4'b1011, 1'b1, 2'd2, 1'b0, 4'b1011, 1'b0); // multi request
    add(4'b0000, 1'b1, 2'd3, 1'b1, 4'b1011, 1'b0);
    add(4'b0000, 1'b1, 2'd1, 1'b1, 4'b0011, 1'b0); // back-to-back
    add(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0);
    add(4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
    add(4'b1000, 1'b0, 2'd0, 1'b0, 4'b1000, 1'b0); // set-over-clear setup
    add(4'b0000, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0);
    add(4'b1000, 1'b1, 2'd3, 1'b0, 4'b1000, 1'b0); // set wins, no dup
    add(4'b0000, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0); // re-presented
    add(4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0);
    add(4'b0010, 1'b0, 2'd3, 1'b0, 4'b0010, 1'b0); // duplicate setup
    add(4'b0000, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0);
    add(4'b0010, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b1); // duplicate pulse
    add(4'b0000, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0); // dup lasts one cycle
    add(4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0);
    add(4'b0001, 1'b0, 2'd1, 1'b0, 4'b0001, 1'b0); // hold-without-ack setup
    add(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0);
    add(4'b1000, 1'b0, 2'd0, 1'b1, 4'b1001, 1'b0); // no pre-emption

    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();

    for (int k = 0; k < tbl.size(); k++) begin
      step(int'(tbl[k].in), tbl[k].ack);
      chk_all($sformatf("tbl%0d", k), int'(tbl[k].exp_out), int'(tbl[k].exp_valid),
              int'(tbl[k].exp_pend), int'(tbl[k].exp_dup));
    end

    // Hold without ack for more cycles, then ack moves to the higher code.
    for (int k = 0; k < 9; k++) begin
      step(0, 1'b0);
      chk_all($sformatf("hold%0d", k), 0, 1, 9, 0);
    end
    step(0, 1'b1);
    chk_all("hold_ack", 3, 1, 8, 0);
    step(0, 1'b1);
    chk_all("hold_done", 3, 0, 0, 0);

    // Asynchronous reset mid-presentation.
    step(4, 1'b0);
    step(0, 1'b0);
    chk_all("pre_reset", 2, 1, 4, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    chk_all("reset_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
    step(0, 1'b0);
    chk_all("post_reset", 0, 0, 0, 0);
    step(0, 1'b1);
    chk_all("post_reset_ack", 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      int in_v;
      bit ack_v;
      in_v  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0;
      ack_v = $urandom_range(0, 2) != 0;
      step_chk_model($sformatf("rand%0d", k), in_v, ack_v);
    end

    // Drain with ack held; every pending code must come out within 5 cycles.
    for (int k = 0; k < 6; k++) step_chk_model($sformatf("drain%0d", k), 0, 1'b1);
    chk("drained.pending", int'(bus.pending), 0);
    chk("drained.valid", int'(bus.valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/req_encoder_4to2.md
Name: req_encoder_4to2

Overview:
Sequential 4-to-2 request encoder. It is the encoding counterpart of the 2-to-4 decoder. Single-cycle request pulses on a 4-bit input are captured into a sticky pending register. Pending requests are presented one at a time as a 2-bit binary code, highest index first, under a valid/ack handshake. It sits in front of any block that consumes a binary index, for example a decoder driving one-hot selects.

Parameters:
N_REQ, 4, number of request lines (fixed at 4 for this block)
CODE_W, 2, code width, equal to log2(N_REQ)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in  input  4  request pulses; bit i requests code i; any number of bits may be set in one cycle
out  output  2  presented code; registered
valid  output  1  out holds a pending request; registered
ack  input  1  consumer accepts out; counts only when valid=1
pending  output  4  current pending register contents
dup  output  1  one-cycle registered pulse: a request arrived for a bit that was already pending and was not being cleared that cycle

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): pending=0000, out=00, valid=0, dup=0, state IDLE. Reset mid-presentation discards all requests. The first edge after release behaves as IDLE.
- Pending update at every edge: pending <= (pending & ~clr) | in.
  - clr = onehot(out) when valid & ack, else 0000.
  - Set wins over clear: if in[i] and clr[i] occur in the same cycle, bit i stays pending.
- dup <= |(in & pending & ~clr).
- Priority function penc(v): index of the highest set bit of v, plus an any-bit flag. 1xxx->11, 01xx->10, 001x->01, 0001->00.
- State IDLE (valid=0):
  - If pending != 0000: out <= penc(pending), valid <= 1, go to PRESENT.
  - Otherwise stay in IDLE; out keeps its last value.
  - Requests on in are not visible to the selection until they are registered. Latency from an in pulse at edge t to valid=1 is 2 edges (pending set at t, valid at t+1).
- State PRESENT (valid=1):
  - out and valid are held stable while ack=0. There is no pre-emption: a newly arrived higher-priority request does not change out.
  - On valid & ack, let rem = pending & ~onehot(out). If rem != 0: out <= penc(rem), valid stays 1, stay in PRESENT. This gives back-to-back, one code per cycle. Otherwise valid <= 0 and go to IDLE.
  - Requests arriving on in during the ack cycle are excluded from rem. They are served from the next selection.
- ack while valid=0 is ignored and has no side effects.
- in=0000 has no effect.
- All outputs are registered. There is no combinational path from in or ack to any output.

Decomposition:
- Shared package req_enc_pkg holds:
  - constants N_REQ=4 and CODE_W=2
  - state enum req_enc_state_t {IDLE, PRESENT}
  - function onehot4(code) returning the 4-bit one-hot of a 2-bit code
- One combinational sub-module, pri_enc_4to2 (inputs v[3:0]; outputs code[1:0], any). It is instantiated twice: once on pending and once on rem.

Test Plan:
- Reset: present code 10 (pending=0100, valid=1), then drive rst_n=0 between edges -> immediately valid=0, out=00, pending=0000, dup=0. After release with in=0000 -> valid stays 0.
- Single request: in=0100 for one cycle at edge t -> pending=0100 after t; valid=1, out=10 after t+1. Ack one cycle -> next edge valid=0, pending=0000, state IDLE.
- Multi-request ordering: in=1011 for one cycle, ack held 1 -> out sequence 11, 01, 00 on consecutive edges with valid continuously 1. Then valid=0 and pending=0000.
- Hold without ack: pending=0001 presented (out=00). Pulse in=1000, ack=0 for 10 cycles -> out stays 00, valid=1, pending=1001. After ack, out=11 on the next edge.
- Set-over-clear: out=11 presented, in=1000 and ack=1 in the same cycle, no other bits pending -> pending stays 1000, dup=0, valid=0 for one cycle, then out=11 and valid=1 again.
- Duplicate: pending=0010 with out=01 presented and ack=0, pulse in=0010 -> dup=1 for exactly one cycle, pending unchanged, out unchanged.
